// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter.
// It merges the always-accepted pipeline write with writes coming back from
// the multicycle unit, which are buffered in a two-entry FIFO. It also keeps
// a per-register scoreboard of outstanding multicycle results. When the FIFO
// head keeps losing to the pipeline, the arbiter asks the pipeline for a
// bubble so that the head can drain.
module wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        armW,
  input  logic        pw_valid,
  input  logic [4:0]  pw_addr,
  input  logic [31:0] pw_data,
  input  logic        sw_valid,
  output logic        sw_ready,
  input  logic [4:0]  sw_addr,
  input  logic [31:0] sw_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        pc_we,
  output logic [31:0] pc_wd,
  output logic [31:0] pending,
  output logic        stall_req
);

  // Secondary-write FIFO storage and bookkeeping
  logic [4:0]  fifoAddr_q [2];
  logic [31:0] fifoData_q [2];
  logic        rdPtr_q, wrPtr_q;
  logic [1:0]  count_q, count_d;

  // Starvation counter and scoreboard
  logic [1:0]  starve_q, starve_d;
  logic [31:0] pending_q, pending_d;

  // Registered write-port outputs
  logic        we3_q, we3_d;
  logic [4:0]  wa3_q, wa3_d;
  logic [31:0] wd3_q, wd3_d;
  logic        pcWe_q, pcWe_d;
  logic [31:0] pcWd_q, pcWd_d;

  // Selection helpers
  logic        fifoFull, fifoEmpty, push, pop, selValid;
  logic [4:0]  headAddr, selAddr;
  logic [31:0] headData, selData;

  // The primary write always wins. The FIFO head is used only when the primary write is idle.
  always_comb begin
    fifoFull  = (count_q == 2'd2);
    fifoEmpty = (count_q == 2'd0);
    headAddr  = fifoAddr_q[rdPtr_q];
    headData  = fifoData_q[rdPtr_q];
    push      = sw_valid && !fifoFull;
    pop       = !pw_valid && !fifoEmpty;
    selValid  = pw_valid || !fifoEmpty;
    selAddr   = pw_valid ? pw_addr : headAddr;
    selData   = pw_valid ? pw_data : headData;
  end

  // Decode the selected write into register-file or PC-redirect form
  always_comb begin
    we3_d  = 1'b0;
    pcWe_d = 1'b0;
    wa3_d  = wa3_q;
    wd3_d  = wd3_q;
    pcWd_d = pcWd_q;
    if (selValid) begin
      if (armW) begin
        if (selAddr[3:0] == 4'hF) begin
          pcWe_d = 1'b1;
          pcWd_d = selData;
        end else begin
          we3_d = 1'b1;
          wa3_d = {1'b0, selAddr[3:0]};
          wd3_d = selData;
        end
      end else if (selAddr != 5'd0) begin
        we3_d = 1'b1;
        wa3_d = selAddr;
        wd3_d = selData;
      end
    end
  end

  // FIFO occupancy, the starvation counter and scoreboard next-state
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (fifoEmpty || pop) begin
      starve_d = 2'd0;
    end else if (starve_q != 2'd3) begin
      starve_d = starve_q + 2'd1;
    end

    pending_d = pending_q;
    if (pop) begin
      pending_d[headAddr] = 1'b0;
    end
    if (issue_valid && !(issue_addr == 5'd0 && !armW)) begin
      pending_d[issue_addr] = 1'b1;
    end
  end

  // State registers, which are cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        fifoAddr_q[i] <= '0;
        fifoData_q[i] <= '0;
      end
      rdPtr_q   <= 1'b0;
      wrPtr_q   <= 1'b0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      we3_q     <= 1'b0;
      wa3_q     <= '0;
      wd3_q     <= '0;
      pcWe_q    <= 1'b0;
      pcWd_q    <= '0;
    end else begin
      if (push) begin
        fifoAddr_q[wrPtr_q] <= sw_addr;
        fifoData_q[wrPtr_q] <= sw_data;
        wrPtr_q             <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      we3_q     <= we3_d;
      wa3_q     <= wa3_d;
      wd3_q     <= wd3_d;
      pcWe_q    <= pcWe_d;
      pcWd_q    <= pcWd_d;
    end
  end

  assign sw_ready  = (count_q != 2'd2);
  assign stall_req = (starve_q == 2'd3);
  assign pending   = pending_q;
  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign pc_we     = pcWe_q;
  assign pc_wd     = pcWd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter. The expected values are worked out by hand in the stimulus sequence.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        armW;
  logic        pw_valid;
  logic [4:0]  pw_addr;
  logic [31:0] pw_data;
  logic        sw_valid;
  logic        sw_ready;
  logic [4:0]  sw_addr;
  logic [31:0] sw_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic [31:0] pending;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  wb_arbiter dut (
    .clk(clk), .reset(reset), .armW(armW),
    .pw_valid(pw_valid), .pw_addr(pw_addr), .pw_data(pw_data),
    .sw_valid(sw_valid), .sw_ready(sw_ready), .sw_addr(sw_addr), .sw_data(sw_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
    .pending(pending), .stall_req(stall_req)
  );

  // 10 ns free-running clock
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive every input to an idle value without advancing time
  task automatic setIdle(input logic arm);
    armW = arm; pw_valid = 1'b0; pw_addr = '0; pw_data = '0;
    sw_valid = 1'b0; sw_addr = '0; sw_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
  endtask

  // Apply one cycle of inputs, then stop just after the rising edge for sampling
  task automatic applyStimulus(input logic arm,
                               input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                               input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                               input logic iv, input logic [4:0] ia);
    armW = arm; pw_valid = pv; pw_addr = pa; pw_data = pd;
    sw_valid = sv; sw_addr = sa; sw_data = sd;
    issue_valid = iv; issue_addr = ia;
    @(posedge clk);
    #1;
  endtask

  // Compare the register-file and PC write ports
  task automatic checkWrite(input string tag, input logic eWe, input logic [4:0] eWa,
                            input logic [31:0] eWd, input logic ePcWe);
    checkOutput({tag, ".we3"}, {31'd0, we3}, {31'd0, eWe});
    checkOutput({tag, ".wa3"}, {27'd0, wa3}, {27'd0, eWa});
    checkOutput({tag, ".wd3"}, wd3, eWd);
    checkOutput({tag, ".pc_we"}, {31'd0, pc_we}, {31'd0, ePcWe});
  endtask

  initial begin
    setIdle(1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkWrite("rst", 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("rst.pc_wd", pc_wd, 32'h0);
    checkOutput("rst.pending", pending, 32'h0);
    checkOutput("rst.stall", {31'd0, stall_req}, 32'd0);
    checkOutput("rst.sw_ready", {31'd0, sw_ready}, 32'd1);
    reset = 1'b0;

    // Primary RISC-V write, which lasts one cycle
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("pw5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("pw5.after", 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);

    // Writes to x0 are discarded. ARM r15 writes are redirected to the PC, and ARM drops bit 4 of the address.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("x0", 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd15, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("r15", 1'b0, 5'd5, 32'hDEADBEEF, 1'b1);
    checkOutput("r15.pc_wd", pc_wd, 32'h100);
    applyStimulus(1'b1, 1'b1, 5'h13, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("arm13", 1'b1, 5'd3, 32'h77, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'h1F, 32'h1F1F, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("arm1f", 1'b0, 5'd3, 32'h77, 1'b1);
    checkOutput("arm1f.pc_wd", pc_wd, 32'h1F1F);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("arm.idle", 1'b0, 5'd3, 32'h77, 1'b0);
    checkOutput("arm.idle.pc_wd", pc_wd, 32'h1F1F);

    // Scoreboard: issue r7, and check that an issue to x0 in RISC-V mode is ignored. Then a secondary write retires r7.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    checkOutput("iss7.pending", pending, 32'h80);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    checkOutput("iss0.pending", pending, 32'h80);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h42, 1'b0, 5'd0);
    checkWrite("push7", 1'b0, 5'd3, 32'h77, 1'b0);
    checkOutput("push7.pending", pending, 32'h80);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("pop7", 1'b1, 5'd7, 32'h42, 1'b0);
    checkOutput("pop7.pending", pending, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("pop7.after", 1'b0, 5'd7, 32'h42, 1'b0);

    // When a scoreboard bit is set and cleared on the same edge, the set wins
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    checkOutput("iss9.pending", pending, 32'h200);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    checkWrite("pop9.setclr", 1'b1, 5'd9, 32'h99, 1'b0);
    checkOutput("pop9.setclr.pending", pending, 32'h200);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h5, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("pop9b", 1'b1, 5'd9, 32'h5, 1'b0);
    checkOutput("pop9b.pending", pending, 32'h0);

    // In ARM mode an issue to r0 is tracked, and a secondary write to r0 lands
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    checkOutput("armiss0.pending", pending, 32'h1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hAB, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("armpop0", 1'b1, 5'd0, 32'hAB, 1'b0);
    checkOutput("armpop0.pending", pending, 32'h0);

    // Starvation: the FIFO fills while primary writes keep winning, a push to the full FIFO is dropped, and a stall request follows
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0);
    checkWrite("stv.a", 1'b1, 5'd1, 32'h1, 1'b0);
    checkOutput("stv.a.sw_ready", {31'd0, sw_ready}, 32'd1);
    applyStimulus(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0);
    checkOutput("stv.b.sw_ready", {31'd0, sw_ready}, 32'd0);
    checkOutput("stv.b.stall", {31'd0, stall_req}, 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0);
    checkOutput("stv.c.stall", {31'd0, stall_req}, 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("stv.d", 1'b1, 5'd4, 32'h4, 1'b0);
    checkOutput("stv.d.stall", {31'd0, stall_req}, 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("stv.bubble", 1'b1, 5'd10, 32'hA0, 1'b0);
    checkOutput("stv.bubble.stall", {31'd0, stall_req}, 32'd0);
    checkOutput("stv.bubble.sw_ready", {31'd0, sw_ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("stv.pop2", 1'b1, 5'd11, 32'hB0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("stv.empty", 1'b0, 5'd11, 32'hB0, 1'b0);

    // A push and a pop on the same edge leave occupancy unchanged, and entries drain in order
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD0, 1'b0, 5'd0);
    checkWrite("pp.push", 1'b0, 5'd11, 32'hB0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hE0, 1'b0, 5'd0);
    checkWrite("pp.both", 1'b1, 5'd13, 32'hD0, 1'b0);
    checkOutput("pp.both.sw_ready", {31'd0, sw_ready}, 32'd1);
    applyStimulus(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd15, 32'hF0, 1'b0, 5'd0);
    checkWrite("pp.prim", 1'b1, 5'd2, 32'h22, 1'b0);
    checkOutput("pp.prim.sw_ready", {31'd0, sw_ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("pp.pop14", 1'b1, 5'd14, 32'hE0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("pp.pop15", 1'b1, 5'd15, 32'hF0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("pp.empty", 1'b0, 5'd15, 32'hF0, 1'b0);

    // A mid-operation reset with a full FIFO and r7 pending discards everything
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    checkOutput("pre.pending", pending, 32'h80);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd20, 32'h1, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'h4, 1'b1, 5'd21, 32'h2, 1'b0, 5'd0);
    checkOutput("pre.sw_ready", {31'd0, sw_ready}, 32'd0);
    setIdle(1'b0);
    reset = 1'b1;
    #1;
    checkWrite("mid.rst", 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("mid.rst.pc_wd", pc_wd, 32'h0);
    checkOutput("mid.rst.pending", pending, 32'h0);
    checkOutput("mid.rst.stall", {31'd0, stall_req}, 32'd0);
    checkOutput("mid.rst.sw_ready", {31'd0, sw_ready}, 32'd1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("post.rst1", 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("post.rst1.sw_ready", {31'd0, sw_ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkWrite("post.rst2", 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("post.rst2.pending", pending, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003: armW  input  1  mode of the write being selected this cycle (1 = ARM, 0 = RISC-V).
REQ-004: pw_valid  input  1  primary (pipeline) write request; always accepted, no ready.
REQ-005: pw_addr  input  5  primary destination register.
REQ-006: pw_data  input  32  primary write data.
REQ-007: sw_valid  input  1  secondary (multicycle unit) write request.
REQ-008: sw_ready  output  1  secondary request accepted when sw_valid && sw_ready at a clock edge.
REQ-009: sw_addr  input  5  secondary destination register.
REQ-010: sw_data  input  32  secondary write data.
REQ-011: issue_valid  input  1  decode issues an op to the multicycle unit; marks issue_addr pending.
REQ-012: issue_addr  input  5  destination register of the issued op.
REQ-013: we3, wa3[4:0], wd3[31:0]  output  register-file write port, registered.
REQ-014: pc_we  output  1, pc_wd  output  32  ARM r15 write redirect, registered.
REQ-015: pending  output  32  scoreboard bitmask, bit i = register i awaiting a secondary write.
REQ-016: stall_req  output  1  requests the pipeline insert a bubble (no primary write) next cycle.

Function
REQ-017: Secondary requests SHALL enter a 2-entry FIFO; sw_ready = FIFO not full (combinational from state only, not from this cycle's pop).
REQ-018: Each cycle the selector SHALL pick: primary if pw_valid, else FIFO head if non-empty, else nothing.
REQ-019: Selected write SHALL appear on outputs exactly one cycle later (we3/pc_we pulse for one cycle); with nothing selected, we3=0 and pc_we=0 next cycle.
REQ-020: A FIFO head SHALL pop only in the cycle it is selected; push and pop in the same cycle SHALL both occur (occupancy unchanged).
REQ-021: RISC-V mode: selected address 0 SHALL produce we3=0, pc_we=0 (write discarded, FIFO entry still popped).
REQ-022: ARM mode: address bits [3:0]==15 SHALL produce pc_we=1, pc_wd=data, we3=0; otherwise wa3={1'b0, addr[3:0]}.
REQ-023: Otherwise we3=1, wa3=addr, wd3=data; wa3/wd3 hold last value when we3=0.
REQ-024: Starvation counter (2 bits) SHALL increment each cycle the FIFO is non-empty and primary is selected; saturates at 3; clears when the head pops or FIFO empty.
REQ-025: stall_req SHALL equal (counter==3); pipeline guarantees pw_valid=0 the following cycle.
REQ-026: pending[i] SHALL set at the edge where issue_valid && issue_addr==i, except issue_addr==0 with armW=0 (ignored).
REQ-027: pending[i] SHALL clear at the edge where a FIFO entry with address i is selected; simultaneous set and clear on the same i SHALL leave it set.
REQ-028: A secondary push when FIFO is full (sw_ready=0) SHALL be ignored; no data lost from the FIFO.

Reset
REQ-029: While reset is high: we3=0, wa3=0, wd3=0, pc_we=0, pc_wd=0, pending=0, stall_req=0, FIFO empty, counter=0, sw_ready=1.
REQ-030: Reset asserted mid-operation SHALL discard FIFO contents and pending bits with no write pulse emitted.

Verification
REQ-031: armW=0, pw_valid, pw_addr=5, pw_data=0xDEADBEEF -> next cycle we3=1, wa3=5, wd3=0xDEADBEEF; following cycle we3=0.
REQ-032: armW=0, pw_addr=0 -> we3=0; armW=1, pw_addr=15, data 0x100 -> pc_we=1, pc_wd=0x100, we3=0.
REQ-033: issue_valid addr 7, then sw push addr 7 data 0x42 with pw_valid=0 -> pending[7]=1 until the edge writing wa3=7, wd3=0x42, then 0.
REQ-034: Two sw pushes with pw_valid held high -> sw_ready=0 after 2nd; stall_req=1 after 3 primary-won cycles; bubble -> head written, counter 0.
REQ-035: Same-cycle push and pop with FIFO at 1 entry -> occupancy stays 1, entries written in order.
REQ-036: Reset pulse with FIFO full and pending=0x80 -> all outputs 0, sw_ready=1, no we3 pulse after release.
